uart_cmd_wrapper: RTL and testbench

//  DUT-side endpoint of the RemoteComm serial link. It is the responder to RemoteComm's initiator.
//  - Receives 8N1 UART bytes on RX and assembles each pair (high byte first) into a 16-bit command.
//  - Presents the command to cmd_proc with a cmd_rdy/clr_cmd_rdy handshake.
//  - Serializes the 8-bit response byte (e.g. 8'hA5 ack) back to the remote on TX.
//  - Sits between the KnightsTour RX/TX pins and cmd_proc.

---
 rtl/uart_cmd_wrapper_if.sv | 34 +++
 rtl/uart_cmd_wrapper.sv | 178 +++++++++++++++++
 tb/tb_uart_cmd_wrapper.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_cmd_wrapper_if.sv
// Command/response handshake between the UART endpoint and cmd_proc.
//   cmd          assembled 16-bit command {high byte, low byte}
//   cmd_rdy      cmd is valid, held until cleared
//   clr_cmd_rdy  cmd_proc has consumed cmd
//   resp         response byte to transmit
//   trmt         1-cycle pulse: start transmitting resp
//   tx_done      response fully sent, held until the next accepted trmt
// master = cmd_proc side, slave = UART endpoint side.
interface uart_cmd_wrapper_if;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic [7:0]  resp;
  logic        trmt;
  logic        tx_done;

  modport master (
    input  cmd,
    input  cmd_rdy,
    input  tx_done,
    output clr_cmd_rdy,
    output resp,
    output trmt
  );

  modport slave (
    output cmd,
    output cmd_rdy,
    output tx_done,
    input  clr_cmd_rdy,
    input  resp,
    input  trmt
  );
endinterface

// File: rtl/uart_cmd_wrapper.sv
// DUT-side endpoint of the RemoteComm serial link.
// Receives 8N1 bytes on RX, pairs them (high byte first) into a 16-bit command offered to
// cmd_proc with a cmd_rdy/clr_cmd_rdy handshake, and serialises response bytes onto TX.
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   RX     serial input from remote, asynchronous, idles high
//   TX     serial output to remote, registered, idles high
//   bus    cmd/cmd_rdy/clr_cmd_rdy/resp/trmt/tx_done handshake (slave side)
module uart_cmd_wrapper #(
  parameter int unsigned BAUD_DIV = 2604  // clk cycles per bit, >= 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               RX,
  output logic               TX,
  uart_cmd_wrapper_if.slave  bus
);

  localparam int unsigned CntW = $clog2(BAUD_DIV + 1);
  localparam logic [CntW-1:0] HalfBaud = CntW'(BAUD_DIV / 2);
  localparam logic [CntW-1:0] FullBaud = CntW'(BAUD_DIV);
  localparam logic [CntW-1:0] LastTx   = CntW'(BAUD_DIV - 1);
  localparam logic [CntW-1:0] CntOne   = CntW'(1);

  typedef enum logic {RxIdle, RxRecv}    rx_state_e;
  typedef enum logic {ByteHigh, ByteLow} byte_state_e;
  typedef enum logic {TxIdle, TxXmit}    tx_state_e;

  // RX path state
  logic            rx_meta_q, rx_sync_q;
  rx_state_e       rx_state_q;
  logic [CntW-1:0] rx_cnt_q;
  logic [3:0]      rx_bit_q;     // 0 = start, 1..8 = data, 9 = stop
  logic [7:0]      rx_shift_q;

  // Command assembly state
  byte_state_e     byte_state_q;
  logic [7:0]      high_q;
  logic [15:0]     cmd_q;
  logic            cmd_rdy_q;

  // TX path state
  tx_state_e       tx_state_q;
  logic [CntW-1:0] tx_cnt_q;
  logic [3:0]      tx_bits_q;    // bits still to be sent after the current one
  logic [8:0]      tx_shift_q;
  logic            tx_q;
  logic            tx_done_q;

  logic rx_sample;
  logic byte_strobe;
  logic frame_err;

  assign rx_sample   = (rx_state_q == RxRecv) && (rx_cnt_q == CntOne);
  assign byte_strobe = rx_sample && (rx_bit_q == 4'd9) && rx_sync_q;
  assign frame_err   = rx_sample && (rx_bit_q == 4'd9) && !rx_sync_q;

  // Synchronizer and bit-level receiver. The first sample lands mid start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_state_q <= RxIdle;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
    end else begin
      rx_meta_q <= RX;
      rx_sync_q <= rx_meta_q;
      unique case (rx_state_q)
        RxIdle: begin
          if (!rx_sync_q) begin
            rx_state_q <= RxRecv;
            rx_cnt_q   <= HalfBaud;
            rx_bit_q   <= '0;
          end
        end
        RxRecv: begin
          if (rx_cnt_q == CntOne) begin
            rx_cnt_q <= FullBaud;
            rx_bit_q <= rx_bit_q + 4'd1;
            if (rx_bit_q == 4'd9) begin
              rx_state_q <= RxIdle;
            end else if (rx_bit_q == 4'd0) begin
              // Start bit gone high again by mid-bit: treat as a glitch.
              if (rx_sync_q) rx_state_q <= RxIdle;
            end else begin
              rx_shift_q <= {rx_sync_q, rx_shift_q[7:1]};
            end
          end else begin
            rx_cnt_q <= rx_cnt_q - CntOne;
          end
        end
        default: rx_state_q <= RxIdle;
      endcase
    end
  end

  // Byte pairing and the cmd_rdy handshake. A new command's set beats a same-cycle clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_state_q <= ByteHigh;
      high_q       <= '0;
      cmd_q        <= '0;
      cmd_rdy_q    <= 1'b0;
    end else begin
      if (frame_err) begin
        byte_state_q <= ByteHigh;
        if (bus.clr_cmd_rdy) cmd_rdy_q <= 1'b0;
      end else if (byte_strobe) begin
        unique case (byte_state_q)
          ByteHigh: begin
            high_q       <= rx_shift_q;
            cmd_rdy_q    <= 1'b0;
            byte_state_q <= ByteLow;
          end
          ByteLow: begin
            cmd_q        <= {high_q, rx_shift_q};
            cmd_rdy_q    <= 1'b1;
            byte_state_q <= ByteHigh;
          end
          default: byte_state_q <= ByteHigh;
        endcase
      end else if (bus.clr_cmd_rdy) begin
        cmd_rdy_q <= 1'b0;
      end
    end
  end

  // Transmitter: start bit is driven directly on acceptance, the remaining nine bits
  // (data LSB first, then stop) come out of the shift register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state_q <= TxIdle;
      tx_cnt_q   <= '0;
      tx_bits_q  <= '0;
      tx_shift_q <= '1;
      tx_q       <= 1'b1;
      tx_done_q  <= 1'b0;
    end else begin
      unique case (tx_state_q)
        TxIdle: begin
          if (bus.trmt) begin
            tx_state_q <= TxXmit;
            tx_q       <= 1'b0;
            tx_shift_q <= {1'b1, bus.resp};
            tx_bits_q  <= 4'd9;
            tx_cnt_q   <= LastTx;
            tx_done_q  <= 1'b0;
          end
        end
        TxXmit: begin
          if (tx_cnt_q == '0) begin
            if (tx_bits_q == 4'd0) begin
              tx_state_q <= TxIdle;
              tx_done_q  <= 1'b1;
            end else begin
              tx_q       <= tx_shift_q[0];
              tx_shift_q <= {1'b1, tx_shift_q[8:1]};
              tx_bits_q  <= tx_bits_q - 4'd1;
              tx_cnt_q   <= LastTx;
            end
          end else begin
            tx_cnt_q <= tx_cnt_q - CntOne;
          end
        end
        default: tx_state_q <= TxIdle;
      endcase
    end
  end

  assign TX          = tx_q;
  assign bus.cmd     = cmd_q;
  assign bus.cmd_rdy = cmd_rdy_q;
  assign bus.tx_done = tx_done_q;

endmodule

// File: tb/tb_uart_cmd_wrapper.sv
// Self-checking bench for uart_cmd_wrapper acting as the RemoteComm side of the link.
// A short bit period keeps the run small; all timing expectations are expressed in B.
module tb_uart_cmd_wrapper;

  localparam int unsigned B = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rx = 1'b1;
  logic tx;

  uart_cmd_wrapper_if bus_if ();

  uart_cmd_wrapper #(.BAUD_DIV(B)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .RX    (rx),
    .TX    (tx),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Command model: pairs bytes as the remote sends them.
  bit          check_en = 1'b0;
  bit          tx_chk_en = 1'b0;
  logic [15:0] exp_cmd = '0;
  bit          exp_rdy = 1'b0;
  bit          have_high = 1'b0;
  logic [7:0]  hi_byte = '0;

  // Response model: frame timeline counted in clocks from the accepted trmt.
  bit          m_busy = 1'b0;
  bit          m_done = 1'b0;
  int          m_cyc = 0;
  logic [9:0]  m_frame = '1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_cyc  <= 0;
    end else if (m_busy) begin
      m_cyc <= m_cyc + 1;
      if (m_cyc + 1 == 10 * B) begin
        m_busy <= 1'b0;
        m_done <= 1'b1;
      end
    end else if (bus_if.trmt) begin
      m_busy  <= 1'b1;
      m_cyc   <= 0;
      m_frame <= {1'b1, bus_if.resp, 1'b0};
      m_done  <= 1'b0;
    end
  end

  // Per-cycle comparison against both models.
  always @(negedge clk) begin
    if (tx_chk_en) begin
      if (m_busy) chk("tx_bit", tx, m_frame[m_cyc / B]);
      else        chk("tx_idle", tx, 1'b1);
      chk("tx_done", bus_if.tx_done, m_busy ? 1'b0 : m_done);
    end
    if (check_en) begin
      chk("cmd", bus_if.cmd, exp_cmd);
      chk("cmd_rdy", bus_if.cmd_rdy, exp_rdy);
    end
  end

  // Remote transmitter: drives one 8N1 frame (or the first nbits of it) onto RX.
  task automatic send_byte(input logic [7:0] b, input bit stop, input int nbits);
    logic [9:0] frame;
    bit meas;
    int lat;
    frame = {stop, b, 1'b0};
    meas = stop && have_high && !exp_rdy;
    lat = 0;
    check_en = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk);
      rx = frame[i];
      for (int j = 1; j < B; j++) begin
        @(negedge clk);
        if (i == 9 && meas && lat == 0 && bus_if.cmd_rdy === 1'b1) lat = j;
      end
    end
    if (nbits < 10) return;
    @(negedge clk);
    rx = 1'b1;
    if (!stop) begin
      have_high = 1'b0;
    end else if (!have_high) begin
      have_high = 1'b1;
      hi_byte   = b;
      exp_rdy   = 1'b0;
    end else begin
      have_high = 1'b0;
      exp_cmd   = {hi_byte, b};
      exp_rdy   = 1'b1;
    end
    if (meas) begin
      // Sync (2) plus half a bit to the stop sample, then one clock to cmd_rdy.
      n_cmp++;
      if (lat < int'(B / 2 + 1) || lat > int'(B / 2 + 5)) begin
        n_bad++;
        $display("FAIL rdy_latency: cmd_rdy after %0d clks of stop bit, required %0d..%0d",
                 lat, B / 2 + 1, B / 2 + 5);
      end
    end
    check_en = 1'b1;
  endtask

  task automatic send_cmd(input logic [15:0] c);
    send_byte(c[15:8], 1'b1, 10);
    send_byte(c[7:0], 1'b1, 10);
  endtask

  task automatic clr_pulse();
    check_en = 1'b0;
    @(negedge clk);
    bus_if.clr_cmd_rdy = 1'b1;
    @(negedge clk);
    bus_if.clr_cmd_rdy = 1'b0;
    chk("clr_cmd_rdy", bus_if.cmd_rdy, 1'b0);
    exp_rdy = 1'b0;
    check_en = 1'b1;
  endtask

  // cmd_proc side: pulse trmt, optionally poke trmt again mid-frame, wait for tx_done.
  task automatic tx_send(input logic [7:0] v, input bit poke);
    int cnt;
    @(negedge clk);
    bus_if.resp = v;
    bus_if.trmt = 1'b1;
    @(negedge clk);
    bus_if.trmt = 1'b0;
    cnt = 1;
    while (bus_if.tx_done !== 1'b1 && cnt < 12 * B) begin
      @(negedge clk);
      cnt++;
      if (poke && cnt == 3 * B) begin
        bus_if.resp = ~v;
        bus_if.trmt = 1'b1;
      end else begin
        bus_if.trmt = 1'b0;
      end
    end
    chk("tx_done_latency", cnt, 10 * B + 1);
  endtask

  // Remote receiver: decodes one frame from TX by mid-bit sampling.
  logic [7:0] dec_byte;
  logic [9:0] dec_bits;

  task automatic decode_tx(output logic [7:0] r, output logic [9:0] bits);
    int w;
    w = 0;
    bits = '1;
    while (tx !== 1'b0 && w < 4 * B) begin
      @(negedge clk);
      w++;
    end
    if (tx !== 1'b0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL tx_start: no start bit within %0d clks", 4 * B);
      r = 8'h00;
      return;
    end
    repeat (B / 2) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      bits[i] = tx;
      if (i < 9) repeat (B) @(negedge clk);
    end
    r = bits[8:1];
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    bus_if.clr_cmd_rdy = 1'b0;
    bus_if.resp = 8'h00;
    bus_if.trmt = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset_tx", tx, 1'b1);
    chk("reset_cmd", bus_if.cmd, 16'h0000);
    chk("reset_cmd_rdy", bus_if.cmd_rdy, 1'b0);
    chk("reset_tx_done", bus_if.tx_done, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    tx_chk_en = 1'b1;
    check_en = 1'b1;

    // 1: basic command and clear
    send_cmd(16'h2000);
    chk("t1_cmd", bus_if.cmd, 16'h2000);
    chk("t1_rdy", bus_if.cmd_rdy, 1'b1);
    clr_pulse();

    // 2: ack response, ignored mid-frame trmt, command received concurrently
    fork
      tx_send(8'hA5, 1'b1);
      decode_tx(dec_byte, dec_bits);
      send_cmd(16'hBEEF);
    join
    chk("t2_remote_resp", dec_byte, 8'hA5);
    chk("t2_tx_bits", dec_bits, 10'b1101001010);
    chk("t2_tx_done", bus_if.tx_done, 1'b1);
    chk("t2_cmd", bus_if.cmd, 16'hBEEF);

    // 3: back-to-back commands without clearing
    send_cmd(16'h4321);
    chk("t3_cmd_a", bus_if.cmd, 16'h4321);
    send_byte(8'h5B, 1'b1, 10);
    chk("t3_rdy_drop", bus_if.cmd_rdy, 1'b0);
    chk("t3_cmd_hold", bus_if.cmd, 16'h4321);
    send_byte(8'hFA, 1'b1, 10);
    chk("t3_cmd_b", bus_if.cmd, 16'h5BFA);
    chk("t3_rdy", bus_if.cmd_rdy, 1'b1);

    // 4: clear twice (second has no effect), then a short low glitch on RX
    clr_pulse();
    clr_pulse();
    chk("t4_cmd_kept", bus_if.cmd, 16'h5BFA);
    @(negedge clk);
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (3 * B) @(negedge clk);
    chk("t4_glitch_rdy", bus_if.cmd_rdy, 1'b0);
    send_cmd(16'h2000);
    chk("t4_cmd", bus_if.cmd, 16'h2000);

    // 5: lone high byte, framing error, then a valid command
    send_byte(8'hAB, 1'b1, 10);
    send_byte(8'h77, 1'b0, 10);
    repeat (2 * B) @(negedge clk);
    send_cmd(16'h1234);
    chk("t5_cmd", bus_if.cmd, 16'h1234);
    chk("t5_rdy", bus_if.cmd_rdy, 1'b1);

    // 6: reset mid TX frame and mid RX low byte
    send_byte(8'h99, 1'b1, 10);
    @(negedge clk);
    bus_if.resp = 8'h00;
    bus_if.trmt = 1'b1;
    @(negedge clk);
    bus_if.trmt = 1'b0;
    send_byte(8'h66, 1'b1, 5);
    chk("t6_tx_low_before", tx, 1'b0);
    tx_chk_en = 1'b0;
    check_en = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_tx", tx, 1'b1);
    chk("t6_rst_rdy", bus_if.cmd_rdy, 1'b0);
    chk("t6_rst_tx_done", bus_if.tx_done, 1'b0);
    chk("t6_rst_cmd", bus_if.cmd, 16'h0000);
    rx = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    exp_cmd = '0;
    exp_rdy = 1'b0;
    have_high = 1'b0;
    repeat (2) @(negedge clk);
    tx_chk_en = 1'b1;
    check_en = 1'b1;
    fork
      tx_send(8'h3C, 1'b0);
      decode_tx(dec_byte, dec_bits);
      send_cmd(16'h0F0F);
    join
    chk("t6_post_cmd", bus_if.cmd, 16'h0F0F);
    chk("t6_post_rdy", bus_if.cmd_rdy, 1'b1);
    chk("t6_post_resp", dec_byte, 8'h3C);

    repeat (4) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
